// File: rtl/jolt_stream_selector.sv
`default_nettype none
// ============================================================================
// Module  : jolt_stream_selector
// Brief   : Streaming greedy monotonic-stack selector; keeps the largest
//           PICK-digit order-preserving subsequence of a BCD digit line.
// Revision: 1.0
// ============================================================================
module jolt_stream_selector #(
  parameter int PICK  = 12,
  parameter int LEN_W = 8,
  parameter int CNT_W = $clog2(PICK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              digit_valid,
  output logic              digit_ready,
  input  logic [3:0]        digit,
  input  logic              digit_last,
  input  logic [LEN_W-1:0]  line_len,
  output logic [4*PICK-1:0] result_bcd,
  output logic              result_valid,
  output logic              len_err
);

  typedef enum logic [0:0] {ST_ACCEPT = 1'b0, ST_POP = 1'b1} state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_len_max = '1;
  localparam logic [31:0]      c_pick    = 32'(PICK);

  state_t              r_state, w_state_nx;
  logic [4*PICK-1:0]   r_stack, w_stack_nx;
  logic [CNT_W-1:0]    r_sp, w_sp_nx;
  logic [LEN_W-1:0]    r_drops, w_drops_nx;
  logic [3:0]          r_hold_digit, w_hold_digit_nx;
  logic                r_hold_last, w_hold_last_nx;
  logic                r_first, w_first_nx;
  logic [LEN_W-1:0]    r_count, w_count_nx;
  logic [LEN_W-1:0]    r_len, w_len_nx;
  logic                r_lerr, w_lerr_nx;
  logic [4*PICK-1:0]   r_result, w_result_nx;
  logic                r_result_valid;
  logic                r_len_err, w_len_err_nx;

  logic                w_hs, w_fire, w_pop, w_eol, w_short;
  logic                w_cand_last, w_err_cur;
  logic [3:0]          w_cand, w_top;
  logic [31:0]         w_len_ext;
  logic [LEN_W-1:0]    w_drops_init, w_drops_cur, w_len_cur;

  always_comb begin
    w_state_nx      = r_state;
    w_stack_nx      = r_stack;
    w_sp_nx         = r_sp;
    w_drops_nx      = r_drops;
    w_hold_digit_nx = r_hold_digit;
    w_hold_last_nx  = r_hold_last;
    w_first_nx      = r_first;
    w_count_nx      = r_count;
    w_len_nx        = r_len;
    w_lerr_nx       = r_lerr;
    w_result_nx     = r_result;
    w_len_err_nx    = r_len_err;
    w_eol           = 1'b0;

    w_top = 4'd0;
    for (int i = 0; i < PICK; i++)
      if (int'(r_sp) == i + 1) w_top = r_stack[4*(PICK-i)-1 -: 4];

    w_hs        = (r_state == ST_ACCEPT) && digit_valid;
    w_fire      = w_hs || (r_state == ST_POP);
    w_cand      = (r_state == ST_POP) ? r_hold_digit : digit;
    w_cand_last = (r_state == ST_POP) ? r_hold_last  : digit_last;

    // Line parameters are taken from line_len only on the first digit.
    w_len_ext    = 32'(line_len);
    w_short      = w_len_ext < c_pick;
    w_drops_init = w_short ? '0 : LEN_W'(w_len_ext - c_pick);
    w_drops_cur  = (w_hs && r_first) ? w_drops_init : r_drops;
    w_err_cur    = (w_hs && r_first) ? w_short      : r_lerr;
    w_len_cur    = (w_hs && r_first) ? line_len     : r_len;

    w_pop = (r_sp != '0) && (w_drops_cur != '0) && (w_top < w_cand);

    if (w_hs) begin
      w_count_nx = (r_count == c_len_max) ? r_count : r_count + c_len_one;
      if (r_first) begin
        w_first_nx = 1'b0;
        w_len_nx   = line_len;
        w_lerr_nx  = w_short;
        w_drops_nx = w_drops_init;
      end
    end

    if (w_fire) begin
      if (w_pop) begin
        w_sp_nx    = r_sp - c_cnt_one;
        w_drops_nx = w_drops_cur - c_len_one;
        for (int i = 0; i < PICK; i++)
          if (int'(r_sp) == i + 1) w_stack_nx[4*(PICK-i)-1 -: 4] = 4'd0;
        if (r_state == ST_ACCEPT) begin
          w_hold_digit_nx = digit;
          w_hold_last_nx  = digit_last;
        end
        w_state_nx = ST_POP;
      end else begin
        if (int'(r_sp) < PICK) begin
          for (int i = 0; i < PICK; i++)
            if (int'(r_sp) == i) w_stack_nx[4*(PICK-i)-1 -: 4] = w_cand;
          w_sp_nx = r_sp + c_cnt_one;
        end else if (w_drops_cur != '0) begin
          w_drops_nx = w_drops_cur - c_len_one;
        end
        w_state_nx = ST_ACCEPT;
        w_eol      = w_cand_last;
      end
    end

    // End of line: publish the updated stack and clear line state together.
    if (w_eol) begin
      w_result_nx  = w_stack_nx;
      w_len_err_nx = w_err_cur || (w_count_nx != w_len_cur);
      w_stack_nx   = '0;
      w_sp_nx      = '0;
      w_count_nx   = '0;
      w_lerr_nx    = 1'b0;
      w_first_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_ACCEPT;
      r_stack        <= '0;
      r_sp           <= '0;
      r_drops        <= '0;
      r_hold_digit   <= 4'd0;
      r_hold_last    <= 1'b0;
      r_first        <= 1'b1;
      r_count        <= '0;
      r_len          <= '0;
      r_lerr         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_len_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_stack        <= w_stack_nx;
      r_sp           <= w_sp_nx;
      r_drops        <= w_drops_nx;
      r_hold_digit   <= w_hold_digit_nx;
      r_hold_last    <= w_hold_last_nx;
      r_first        <= w_first_nx;
      r_count        <= w_count_nx;
      r_len          <= w_len_nx;
      r_lerr         <= w_lerr_nx;
      r_result       <= w_result_nx;
      r_result_valid <= w_eol;
      r_len_err      <= w_len_err_nx;
    end
  end

  assign digit_ready  = (r_state == ST_ACCEPT);
  assign result_bcd   = r_result;
  assign result_valid = r_result_valid;
  assign len_err      = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_jolt_stream_selector.sv
`default_nettype none
// tb_jolt_stream_selector: PICK=12 and PICK=2 instances checked against a
// maximum-subsequence reference model.
module tb_jolt_stream_selector;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_last;
  logic [7:0]  in_len;
  int          sel;

  logic        w_v12, w_v2;
  logic        rdy12, rdy2, rv12, rv2, err12, err2;
  logic [47:0] res12;
  logic [7:0]  res2;

  logic [48:0] q12[$];
  logic [48:0] q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  assign w_v12 = in_valid && (sel == 0);
  assign w_v2  = in_valid && (sel == 1);

  jolt_stream_selector #(.PICK(12), .LEN_W(8)) u_dut12 (
    .clk(clk), .rst(rst), .digit_valid(w_v12), .digit_ready(rdy12),
    .digit(in_digit), .digit_last(in_last), .line_len(in_len),
    .result_bcd(res12), .result_valid(rv12), .len_err(err12)
  );

  jolt_stream_selector #(.PICK(2), .LEN_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .digit_valid(w_v2), .digit_ready(rdy2),
    .digit(in_digit), .digit_last(in_last), .line_len(in_len),
    .result_bcd(res2), .result_valid(rv2), .len_err(err2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rv12 === 1'b1) q12.push_back({err12, res12});
    if (rv2 === 1'b1)  q2.push_back({err2, 40'd0, res2});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Largest order-preserving subsequence of length pick; short lines keep all.
  function automatic logic [48:0] model(input iq_t q, input int pick);
    logic [47:0] v;
    int n, start, best, bi;
    v = '0;
    n = q.size();
    start = 0;
    if (n < pick) begin
      for (int k = 0; k < pick; k++) v = {v[43:0], (k < n) ? 4'(q[k]) : 4'd0};
    end else begin
      for (int k = 0; k < pick; k++) begin
        best = -1;
        bi = start;
        for (int j = start; j <= n - pick + k; j++)
          if (q[j] > best) begin best = q[j]; bi = j; end
        v = {v[43:0], 4'(best)};
        start = bi + 1;
      end
    end
    return {(n < pick), v};
  endfunction

  function automatic iq_t str2q(input string s);
    iq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(int'(s.getc(i)) - 48);
    return q;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_digit(input int s, input int d, input bit last, input int len);
    int  n;
    logic rdy;
    bit  done;
    n = 0;
    done = 0;
    sel = s;
    in_valid = 1'b1;
    in_digit = 4'(d);
    in_last = last;
    in_len = 8'(len);
    while (!done) begin
      rdy = (s == 0) ? rdy12 : rdy2;
      @(posedge clk); #1;
      if (rdy) done = 1;
      else begin
        stalls++;
        n++;
        if (n > 50) begin
          check("ready_timeout", {63'd0, rdy}, 64'd1);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_line(input int s, input int len, input iq_t q);
    for (int i = 0; i < q.size(); i++) send_digit(s, q[i], i == q.size() - 1, len);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_result(input int s, input string tag, input logic [48:0] exp);
    int n;
    logic [48:0] r;
    n = 0;
    while (((s == 0) ? q12.size() : q2.size()) == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (((s == 0) ? q12.size() : q2.size()) == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      r = (s == 0) ? q12.pop_front() : q2.pop_front();
      check(tag, {15'd0, r}, {15'd0, exp});
    end
  endtask

  string       lines[4] = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
  logic [47:0] exp12[4] = '{48'h987654321111, 48'h811111111119, 48'h434234234278, 48'h888911112111};
  logic [7:0]  exp2[4]  = '{8'h98, 8'h89, 8'h78, 8'h92};

  initial begin
    iq_t q;
    int  len, s;
    rst = 1'b1;
    in_valid = 1'b0;
    in_digit = 4'd0;
    in_last = 1'b0;
    in_len = 8'd0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready12", {63'd0, rdy12}, 64'd1);
    check("reset_ready2", {63'd0, rdy2}, 64'd1);
    check("reset_rv12", {63'd0, rv12}, 64'd0);
    check("reset_res12", {16'd0, res12}, 64'd0);
    check("reset_err12", {63'd0, err12}, 64'd0);
    check("reset_res2", {56'd0, res2}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer lines on both widths
    for (int i = 0; i < 4; i++) begin
      send_line(0, 15, str2q(lines[i]));
      expect_result(0, "kat12", {1'b0, exp12[i]});
      send_line(1, 15, str2q(lines[i]));
      expect_result(1, "kat2", {1'b0, 40'd0, exp2[i]});
    end

    // Each pop stalls one cycle
    stalls = 0;
    send_digit(1, 1, 0, 4);
    send_digit(1, 2, 0, 4);
    send_digit(1, 3, 0, 4);
    send_digit(1, 9, 1, 4);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("stall_count", 64'(stalls), 64'd2);
    check("stall_rv_high", {63'd0, rv2}, 64'd1);
    @(posedge clk); #1;
    check("stall_rv_pulse", {63'd0, rv2}, 64'd0);
    expect_result(1, "stall_res", {1'b0, 40'd0, 8'h39});

    // Back-to-back lines with no idle gap
    send_digit(1, 5, 0, 3);
    send_digit(1, 5, 0, 3);
    send_digit(1, 5, 1, 3);
    send_digit(1, 1, 0, 2);
    send_digit(1, 9, 1, 2);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("gap_pulses", 64'(q2.size()), 64'd2);
    expect_result(1, "gap_res_a", {1'b0, 40'd0, 8'h55});
    expect_result(1, "gap_res_b", {1'b0, 40'd0, 8'h19});

    // Length errors
    send_line(0, 3, str2q("456"));
    expect_result(0, "short_len", {1'b1, 48'h456000000000});
    send_line(0, 15, str2q("98765432111111"));
    expect_result(0, "early_last", {1'b1, 48'h987654321111});

    // Reset in mid-line abandons it
    q = str2q("9876543");
    for (int i = 0; i < 7; i++) send_digit(0, q[i], 0, 15);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, rdy12}, 64'd1);
    check("midrst_rv", {63'd0, rv12}, 64'd0);
    check("midrst_res", {16'd0, res12}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_result", 64'(q12.size()), 64'd0);
    send_line(0, 15, str2q("987654321111111"));
    expect_result(0, "midrst_next", {1'b0, 48'h987654321111});

    // Random well-formed lines
    for (int t = 0; t < 30; t++) begin
      s = t % 2;
      len = (s == 0) ? $urandom_range(10, 30) : $urandom_range(1, 20);
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : $urandom_range(0, 2));
      send_line(s, len, q);
      expect_result(s, (s == 0) ? "rand12" : "rand2", model(q, (s == 0) ? 12 : 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
